// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its MDU timer.
package pipe_hazard_ctrl_pkg;
  localparam int RAW = 5;
  localparam logic [RAW-1:0] REG_ZERO = '0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } haz_state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_mdu_timer.sv
// Tracks the multiply/divide busy window: loads MDU_LAT-1 on start, counts down to 0.
module haz_mdu_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  output haz_state_e state_o,
  output logic       busy_o
);
  haz_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (start_i) begin
          state_d = MDU_WAIT;
          cnt_d   = CNT_W'(MDU_LAT - 1);
        end
      end
      MDU_WAIT: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign busy_o  = rst & (state_q == MDU_WAIT);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencing: branch flush, load-use / MDU stalls, imem wait.
// Optional perf counters under HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6,
  parameter int RAW     = pipe_hazard_ctrl_pkg::RAW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic           id_uses_rt,
  input  logic           ex_mem_read,
  input  logic [RAW-1:0] ex_rt,
  input  logic           ex_branch_taken,
  input  logic           id_mdu_start,
  input  logic           id_mdu_read,
  input  logic           imem_ready,
  output logic           pc_wr,
  output logic           if_id_wr,
  output logic           if_id_flush,
  output logic           id_ex_flush,
  output logic           mdu_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]    perf_stall_cyc,
  output logic [31:0]    perf_flush_cnt,
  output logic [31:0]    perf_mdu_hold
`endif
);
  haz_state_e state;
  logic       load_use, mdu_hold, mdu_start;

  assign load_use = ex_mem_read && (ex_rt != RAW'(REG_ZERO)) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mdu_hold = (state == MDU_WAIT) && (id_mdu_start || id_mdu_read);
  // In MDU_WAIT a new start is itself a hold, so only RUN can launch.
  assign mdu_start = id_mdu_start && !ex_branch_taken && !load_use && !mdu_hold;

  haz_mdu_timer #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start_i (mdu_start),
    .state_o (state),
    .busy_o  (mdu_busy)
  );

  always_comb begin
    pc_wr       = 1'b1;
    if_id_wr    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst) begin
      pc_wr       = 1'b0;
      if_id_wr    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use || mdu_hold) begin
      pc_wr       = 1'b0;
      if_id_wr    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_wr       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q, flush_q, hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
      hold_q  <= '0;
    end else begin
      if (!pc_wr)          stall_q <= stall_q + 32'd1;
      if (ex_branch_taken) flush_q <= flush_q + 32'd1;
      if (mdu_hold)        hold_q  <= hold_q + 32'd1;
    end
  end

  assign perf_stall_cyc = stall_q;
  assign perf_flush_cnt = flush_q;
  assign perf_mdu_hold  = hold_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken;
  logic       id_mdu_start, id_mdu_read, imem_ready;
  logic       pc_wr, if_id_wr, if_id_flush, id_ex_flush, mdu_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_mdu_hold;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(6), .RAW(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .id_mdu_start    (id_mdu_start),
    .id_mdu_read     (id_mdu_read),
    .imem_ready      (imem_ready),
    .pc_wr           (pc_wr),
    .if_id_wr        (if_id_wr),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mdu_busy        (mdu_busy)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cyc  (perf_stall_cyc),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_mdu_hold   (perf_mdu_hold)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;
  // model: remaining busy cycles of the MDU, plus event tallies
  int busy_left = 0;
  int m_stall = 0, m_flush = 0, m_hold = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    id_mdu_start = 1'b0; id_mdu_read = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic step(input string tag);
    bit lu, hold, e_pc, e_ifw, e_iff, e_ief;
    @(negedge clk);
    lu   = ex_mem_read && ex_rt != 0 &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    hold = busy_left > 0 && (id_mdu_start || id_mdu_read);
    if (ex_branch_taken)   {e_pc, e_ifw, e_iff, e_ief} = 4'b1111;
    else if (lu || hold)   {e_pc, e_ifw, e_iff, e_ief} = 4'b0001;
    else if (!imem_ready)  {e_pc, e_ifw, e_iff, e_ief} = 4'b0110;
    else                   {e_pc, e_ifw, e_iff, e_ief} = 4'b1100;
    chk({tag, ".pc_wr"},       32'(pc_wr),       32'(e_pc));
    chk({tag, ".if_id_wr"},    32'(if_id_wr),    32'(e_ifw));
    chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(e_iff));
    chk({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(e_ief));
    chk({tag, ".mdu_busy"},    32'(mdu_busy),    32'(busy_left > 0));
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ".perf_stall"},  perf_stall_cyc, 32'(m_stall));
    chk({tag, ".perf_flush"},  perf_flush_cnt, 32'(m_flush));
    chk({tag, ".perf_hold"},   perf_mdu_hold,  32'(m_hold));
`endif
    @(posedge clk);
    if (!e_pc) m_stall++;
    if (ex_branch_taken) m_flush++;
    if (hold) m_hold++;
    if (busy_left > 0) busy_left--;
    else if (id_mdu_start && !ex_branch_taken && !lu) busy_left = LAT;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc_wr"},       32'(pc_wr),       32'd0);
    chk({tag, ".if_id_wr"},    32'(if_id_wr),    32'd0);
    chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'd1);
    chk({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'd1);
    chk({tag, ".mdu_busy"},    32'(mdu_busy),    32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #12;
    chk_reset("rst");
    @(posedge clk); #1;
    rst = 1'b1;

    step("dflt");
    // load-use on rs, then load leaves EX
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; step("lu_rs");
    ex_mem_read = 0; step("lu_rs_after");
    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; step("lu_r0");
    // rt only matters when the instruction reads rt
    idle(); ex_mem_read = 1; ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; step("lu_rt_unused");
    id_uses_rt = 1; step("lu_rt_used");
    idle(); step("lu_rt_after");
    // branch beats load-use and imem wait
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; imem_ready = 0; ex_branch_taken = 1;
    step("br_prio");
    idle();
    // mult then mfhi held for LAT cycles
    id_mdu_start = 1; step("mul_c0");
    id_mdu_start = 0; id_mdu_read = 1;
    for (int i = 1; i <= LAT + 1; i++) step($sformatf("mfhi_c%0d", i));
    idle();
    // imem wait for 3 cycles
    imem_ready = 0;
    for (int i = 0; i < 3; i++) step($sformatf("imem_w%0d", i));
    imem_ready = 1; step("imem_done");

    // async reset in the middle of MDU_WAIT
    id_mdu_start = 1; step("mul_rst0");
    id_mdu_start = 0; step("mul_rst1");
    #2 rst = 1'b0;
    #1 chk_reset("rst_mid");
    busy_left = 0; m_stall = 0; m_flush = 0; m_hold = 0;
    @(posedge clk); #1;
    rst = 1'b1;
`ifdef HAZ_PERF_CNT_EN
    chk("rst_perf_stall", perf_stall_cyc, 32'd0);
    chk("rst_perf_flush", perf_flush_cnt, 32'd0);
    chk("rst_perf_hold",  perf_mdu_hold,  32'd0);
`endif
    step("post_rst");

    for (int i = 0; i < 400; i++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_mem_read     = ($urandom_range(0, 9) < 3);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      id_mdu_start    = ($urandom_range(0, 99) < 15);
      id_mdu_read     = ($urandom_range(0, 99) < 20);
      imem_ready      = ($urandom_range(0, 99) < 85);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
